// File: rtl/reaction_timer_pkg.sv
// -----------------------------------------------------------------------------
// reaction_timer_pkg
// Shared constants for the reaction timer: FSM state encodings, the LFSR seed
// and tap mask, and the display constants.
// Also provides lfsrNext, the single-step helper for the Fibonacci LFSR.
// -----------------------------------------------------------------------------
package reaction_timer_pkg;

   // FSM state encodings. These are plain constants rather than an enum so
   // older tools and existing test vectors keep working.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_TIMING = 3'd2;
   localparam logic [2:0] ST_DONE   = 3'd3;
   localparam logic [2:0] ST_FAULT  = 3'd4;

   // 16-bit Fibonacci LFSR with taps 16,14,13,11, which are bits 15,13,12,10.
   // This polynomial is maximal length. Starting from a nonzero seed, the
   // register therefore never reaches all-zero.
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Display constants: the saturation value and the blank pattern that the
   // 7-segment decoder renders as an empty display.
   localparam logic [15:0] BCD_MAX   = 16'h9999;
   localparam logic [15:0] BCD_BLANK = 16'hFFFF;

   // One LFSR step: shift left and feed back the XOR of the tapped bits.
   function automatic logic [15:0] lfsrNext(input logic [15:0] value);
      return {value[14:0], ^(value & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/reaction_timer_core_bcd.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD up-counter with synchronous clear and a saturation flag.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, clears the count
//   clr   - synchronous clear, clears the count
//   inc   - add one to the count; ignored once the count reaches 9999
//   bcd   - four BCD digits, [3:0] least significant
//   sat   - high while the count is 9999
// -----------------------------------------------------------------------------
module bcd_counter4 (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] bcd,
   output logic        sat
);

   logic [15:0] nextBcd;
   logic        carry;

   assign sat = (bcd == 16'h9999);

   // Ripple the +1 through the digits. A digit at 9 wraps to 0 and passes the
   // carry on. The first digit below 9 absorbs the carry.
   always_comb begin
      nextBcd = bcd;
      carry   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (bcd[4*i +: 4] == 4'd9) begin
               nextBcd[4*i +: 4] = 4'd0;
            end else begin
               nextBcd[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
               carry             = 1'b0;
            end
         end
      end
   end

   // The count register. Saturation blocks the increment, so the count holds
   // at 9999 and never wraps to 0000.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         bcd <= 16'h0000;
      end else if (inc && !sat) begin
         bcd <= nextBcd;
      end
   end

endmodule

// File: rtl/reaction_timer_core.sv
// -----------------------------------------------------------------------------
// reaction_timer_core
// Reaction timer. The start pulse arms a trial and begins a pseudo-random
// delay. When the delay expires the stimulus LED lights and elapsed
// milliseconds are counted in BCD. The count stops on stop or saturates at 9999.
// A stop during the delay is reported as a false start.
// Ports:
//   clk          - system clock
//   reset        - synchronous active-high reset
//   start        - one-cycle pulse, arms a trial from IDLE
//   stop         - one-cycle pulse, user reaction
//   clear        - one-cycle pulse, returns to IDLE from any state
//   bcd_out      - four BCD digits of elapsed ms, 16'hFFFF blanks the display
//   stimulus_led - high while the stimulus is shown
//   busy         - high while waiting or timing
//   early        - false-start flag
//   timeout      - the count saturated at 9999
// -----------------------------------------------------------------------------
module reaction_timer_core #(
   parameter int TICK_DIV     = 50000,
   parameter int MIN_DELAY_MS = 1000,
   parameter int RAND_BITS    = 11
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   output logic [15:0] bcd_out,
   output logic        stimulus_led,
   output logic        busy,
   output logic        early,
   output logic        timeout
);

   import reaction_timer_pkg::*;

   localparam int DELAY_SPAN = MIN_DELAY_MS + (1 << RAND_BITS);
   localparam int DW         = (DELAY_SPAN > 1) ? $clog2(DELAY_SPAN) : 1;
   localparam int PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [2:0]    state;
   logic [2:0]    nextState;
   logic [PW-1:0] prescale;
   logic          tick;
   logic [DW-1:0] delay;
   logic [15:0]   lfsr;
   logic [15:0]   count;
   logic          countClr;
   logic          countInc;
   logic          countSat;

   assign tick = (prescale == PW'(TICK_DIV - 1));

   // The counter only tracks elapsed ms. A false start shows as a blank
   // display, and the early flag is a register, so this mux still changes
   // exactly one cycle after the causing event.
   assign bcd_out = early ? BCD_BLANK : count;

   bcd_counter4 u_count (
      .clk   (clk),
      .reset (reset),
      .clr   (countClr),
      .inc   (countInc),
      .bcd   (count),
      .sat   (countSat)
   );

   // Next-state and counter control.
   // clear overrides everything except reset.
   // In WAIT, stop beats the delay expiry: pressing before the LED is seen is
   // always a false start.
   // In TIMING, stop beats a coincident tick, so the displayed count never
   // advances past the moment of the press.
   // A tick that arrives while the count already reads 9999 ends the trial as
   // a timeout.
   always_comb begin
      nextState = state;
      countClr  = 1'b0;
      countInc  = 1'b0;
      if (clear) begin
         nextState = ST_IDLE;
         countClr  = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  nextState = ST_WAIT;
                  countClr  = 1'b1;
               end
            end
            ST_WAIT: begin
               if (stop) begin
                  nextState = ST_FAULT;
               end else if (tick && (delay <= DW'(1))) begin
                  nextState = ST_TIMING;
               end
            end
            ST_TIMING: begin
               if (stop) begin
                  nextState = ST_DONE;
               end else if (tick) begin
                  if (countSat) begin
                     nextState = ST_DONE;
                  end else begin
                     countInc = 1'b1;
                  end
               end
            end
            ST_DONE:  nextState = ST_DONE;
            ST_FAULT: nextState = ST_FAULT;
            default:  nextState = ST_IDLE;
         endcase
      end
   end

   // State, prescaler, delay, LFSR and registered flags.
   // The prescaler restarts on entry to WAIT and to TIMING. This makes the
   // first tick of each phase land a full millisecond after entry.
   // The delay is loaded from the LFSR value that is present in the cycle
   // start is seen.
   // The flags are computed from nextState, so every output reflects the new
   // state in the cycle right after the event.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         prescale     <= '0;
         delay        <= '0;
         lfsr         <= LFSR_SEED;
         stimulus_led <= 1'b0;
         busy         <= 1'b0;
         early        <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         state <= nextState;
         lfsr  <= lfsrNext(lfsr);

         if (tick ||
             ((nextState == ST_WAIT) && (state != ST_WAIT)) ||
             ((nextState == ST_TIMING) && (state != ST_TIMING))) begin
            prescale <= '0;
         end else begin
            prescale <= prescale + PW'(1);
         end

         if ((state == ST_IDLE) && (nextState == ST_WAIT)) begin
            delay <= DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
         end else if ((state == ST_WAIT) && tick && (delay != '0)) begin
            delay <= delay - DW'(1);
         end

         stimulus_led <= (nextState == ST_TIMING);
         busy         <= (nextState == ST_WAIT) || (nextState == ST_TIMING);
         early        <= (nextState == ST_FAULT);
         timeout      <= (nextState == ST_DONE) &&
                         (timeout || ((state == ST_TIMING) && !stop));
      end
   end

endmodule
